// File: rtl/memwrite_checker_pkg.sv
// memwrite_checker_pkg: state encoding, default widths and index-width helper shared by the write checker.
package memwrite_checker_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_NUM_EXP = 4;
  localparam int DEF_CNT_W   = 16;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/memwrite_exp_table.sv
// memwrite_exp_table: expected (address, data) register file; compares the bus write against the entries
// selected by sel and returns the lowest-index hit as a one-hot vector.
import memwrite_checker_pkg::*;

module memwrite_exp_table #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_EXP = DEF_NUM_EXP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [idx_w(NUM_EXP)-1:0]  idx,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]          adr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_EXP-1:0]         sel,
  output logic [NUM_EXP-1:0]         first
);
  logic [ADDR_W-1:0]  addr_q [NUM_EXP];
  logic [DATA_W-1:0]  data_q [NUM_EXP];
  logic [NUM_EXP-1:0] cand;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (we && int'(idx) < NUM_EXP) begin
      addr_q[idx] <= wr_addr;
      data_q[idx] <= wr_data;
    end
  end
  for (genvar g = 0; g < NUM_EXP; g++) begin : g_cmp
    assign cand[g] = sel[g] && addr_q[g] == adr && data_q[g] == wdata;
  end
  // two's-complement trick isolates the lowest set bit
  assign first = cand & (~cand + NUM_EXP'(1));
endmodule

// File: rtl/memwrite_checker.sv
// memwrite_checker: run monitor checking data-memory writes against an expected-write table with scratch
// tolerance and timeout. Define MEMWRITE_CHECKER_ANY_ORDER_EN to accept expected writes in any order.
import memwrite_checker_pkg::*;

module memwrite_checker #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_EXP = DEF_NUM_EXP,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_W-1:0]             timeout_lim,
  input  logic [$clog2(NUM_EXP+1)-1:0] exp_count,
  input  logic                         exp_we,
  input  logic [idx_w(NUM_EXP)-1:0]    exp_idx,
  input  logic [ADDR_W-1:0]            exp_addr,
  input  logic [DATA_W-1:0]            exp_data,
  input  logic                         ign_en,
  input  logic [ADDR_W-1:0]            ign_addr,
  input  logic                         memwrite,
  input  logic [ADDR_W-1:0]            dataadr,
  input  logic [DATA_W-1:0]            writedata,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic [$clog2(NUM_EXP+1)-1:0] match_cnt,
  output logic [CNT_W-1:0]             ign_cnt,
  output logic [CNT_W-1:0]             cycle_cnt,
  output logic [ADDR_W-1:0]            fail_addr,
  output logic [DATA_W-1:0]            fail_data
);
  localparam int CW = $clog2(NUM_EXP+1);
  state_t             state, nxt;
  logic [CW-1:0]      count_eff;
  logic [NUM_EXP-1:0] sel, first;
  logic               match, ign_hit;
  assign count_eff = exp_count > CW'(NUM_EXP) ? CW'(NUM_EXP) : exp_count;
  assign match     = |first;
  assign ign_hit   = ign_en && dataadr == ign_addr;
`ifdef MEMWRITE_CHECKER_ANY_ORDER_EN
  logic [NUM_EXP-1:0] mask;
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_EXP; i++) sel[i] = i < int'(count_eff) && !mask[i];
  end
`else
  assign sel = NUM_EXP'(1) << match_cnt;
`endif
  memwrite_exp_table #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_EXP(NUM_EXP)) u_table (
    .clk(clk), .reset(reset), .we(exp_we && state != RUN), .idx(exp_idx),
    .wr_addr(exp_addr), .wr_data(exp_data), .adr(dataadr), .wdata(writedata),
    .sel(sel), .first(first)
  );
  always_comb begin
    nxt = state;
    if (start) nxt = RUN;
    else if (state == RUN) begin
      if (count_eff == '0) nxt = PASS;
      else if (memwrite && match && match_cnt + 1'b1 == count_eff) nxt = PASS;
      else if (memwrite && !match && !ign_hit) nxt = FAIL;
      else if (timeout_lim != '0 && cycle_cnt + 1'b1 == timeout_lim) nxt = TIMEOUT;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      match_cnt <= '0;
      ign_cnt   <= '0;
      cycle_cnt <= '0;
      fail_addr <= '0;
      fail_data <= '0;
`ifdef MEMWRITE_CHECKER_ANY_ORDER_EN
      mask      <= '0;
`endif
    end else begin
      state   <= nxt;
      busy    <= nxt == RUN;
      done    <= nxt == PASS || nxt == FAIL || nxt == TIMEOUT;
      pass    <= nxt == PASS;
      fail    <= nxt == FAIL;
      timeout <= nxt == TIMEOUT;
      if (start) begin
        match_cnt <= '0;
        ign_cnt   <= '0;
        cycle_cnt <= '0;
        fail_addr <= '0;
        fail_data <= '0;
`ifdef MEMWRITE_CHECKER_ANY_ORDER_EN
        mask      <= '0;
`endif
      end else if (state == RUN) begin
        cycle_cnt <= cycle_cnt + 1'b1;
        if (memwrite && count_eff != '0) begin
          if (match) begin
            match_cnt <= match_cnt + 1'b1;
`ifdef MEMWRITE_CHECKER_ANY_ORDER_EN
            mask      <= mask | first;
`endif
          end else if (ign_hit) begin
            ign_cnt <= &ign_cnt ? ign_cnt : ign_cnt + 1'b1;
          end else begin
            fail_addr <= dataadr;
            fail_data <= writedata;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_memwrite_checker.sv
// tb_memwrite_checker: directed self-checking bench for memwrite_checker (default 4-entry build).
module tb_memwrite_checker;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [15:0] timeout_lim = '0;
  logic [2:0]  exp_count = '0;
  logic        exp_we = 1'b0;
  logic [1:0]  exp_idx = '0;
  logic [31:0] exp_addr = '0, exp_data = '0;
  logic        ign_en = 1'b0;
  logic [31:0] ign_addr = '0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0, writedata = '0;
  logic        busy, done, pass, fail, timeout;
  logic [2:0]  match_cnt;
  logic [15:0] ign_cnt, cycle_cnt;
  logic [31:0] fail_addr, fail_data;
  int errors = 0, checks = 0;

  memwrite_checker dut (
    .clk(clk), .reset(reset), .start(start), .timeout_lim(timeout_lim), .exp_count(exp_count),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .ign_en(ign_en), .ign_addr(ign_addr), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .match_cnt(match_cnt), .ign_cnt(ign_cnt), .cycle_cnt(cycle_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_idx = i; exp_addr = a; exp_data = d;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match_cnt, 0);
    chk("rst_cycle", cycle_cnt, 0);
    reset = 1'b1;
    tick();
    // single expected write with scratch tolerance
    load(0, 84, 7);
    exp_count = 1; ign_en = 1'b1; ign_addr = 80; timeout_lim = 100;
    go();
    chk("run_busy", busy, 1);
    chk("run_cycle0", cycle_cnt, 0);
    wr(80, 5);
    wr(80, 6);
    chk("ign_cnt2", ign_cnt, 2);
    chk("ign_busy", busy, 1);
    wr(84, 7);
    chk("single_pass", pass, 1);
    chk("single_done", done, 1);
    chk("single_match", match_cnt, 1);
    chk("single_cycle", cycle_cnt, 3);
    // mismatch, restarted from PASS
    go();
    chk("rearm_pass_clr", pass, 0);
    wr(88, 7);
    chk("mm_fail", fail, 1);
    chk("mm_addr", fail_addr, 88);
    chk("mm_data", fail_data, 7);
    chk("mm_match", match_cnt, 0);
    wr(84, 7);
    chk("mm_hold_fail", fail, 1);
    chk("mm_hold_match", match_cnt, 0);
    chk("mm_hold_addr", fail_addr, 88);
    // timeout, restarted from FAIL
    ign_en = 1'b0;
    go();
    chk("rearm_busy", busy, 1);
    chk("rearm_fail_clr", fail, 0);
    chk("rearm_faddr_clr", fail_addr, 0);
    repeat (99) tick();
    chk("to_not_yet", timeout, 0);
    chk("to_cycle99", cycle_cnt, 99);
    tick();
    chk("to_hit", timeout, 1);
    chk("to_cycle100", cycle_cnt, 100);
    go();
    repeat (99) tick();
    wr(84, 7);
    chk("to_pass_wins", pass, 1);
    chk("to_pass_not_to", timeout, 0);
    chk("to_pass_cycle", cycle_cnt, 100);
    // ordering
    load(0, 4, 1);
    load(1, 8, 2);
    exp_count = 2;
    go();
    wr(8, 2);
`ifdef MEMWRITE_CHECKER_ANY_ORDER_EN
    chk("ord_first_busy", busy, 1);
    chk("ord_first_match", match_cnt, 1);
    wr(4, 1);
    chk("ord_pass", pass, 1);
    chk("ord_match", match_cnt, 2);
`else
    chk("ord_fail", fail, 1);
    chk("ord_faddr", fail_addr, 8);
    wr(4, 1);
    chk("ord_hold_fail", fail, 1);
    chk("ord_hold_faddr", fail_addr, 8);
`endif
    // table writes during RUN are ignored; async reset mid-run
    go();
    load(0, 12, 3);
    wr(4, 1);
    chk("we_run_ignored", match_cnt, 1);
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_match", match_cnt, 0);
    chk("arst_cycle", cycle_cnt, 0);
    chk("arst_done", done, 0);
    #2 reset = 1'b1;
    tick();
    exp_count = 1;
    go();
    wr(0, 0);
    chk("tbl_cleared_pass", pass, 1);
    load(0, 4, 1);
    load(1, 8, 2);
    exp_count = 2;
    go();
    wr(4, 1);
    wr(8, 2);
    chk("reload_pass", pass, 1);
    chk("reload_match", match_cnt, 2);
    // edge configurations
    exp_count = 0;
    go();
    chk("zero_busy", busy, 1);
    tick();
    chk("zero_pass", pass, 1);
    chk("zero_cycle", cycle_cnt, 1);
    load(0, 16, 10);
    load(1, 20, 11);
    load(2, 24, 12);
    load(3, 28, 13);
    exp_count = 4;
    go();
    wr(16, 10);
    wr(20, 11);
    wr(24, 12);
    chk("full_busy3", busy, 1);
    chk("full_match3", match_cnt, 3);
    wr(28, 13);
    chk("full_pass", pass, 1);
    chk("full_match4", match_cnt, 4);
    exp_count = 7;
    go();
    wr(16, 10);
    wr(20, 11);
    wr(24, 12);
    wr(28, 13);
    chk("clamp_pass", pass, 1);
    chk("clamp_match", match_cnt, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
